// File: rtl/ddr2_responder.sv
// CPU-side DDR2 word responder: a direct-mapped, write-through word cache in front of a
// generic backend request/response port. Read hits complete without stalling.
//   state   | meaning
//   IDLE    | accepting CPU requests; read hits are served here
//   WR_REQ  | write-through request presented to backend
//   RD_REQ  | read-miss request presented to backend
//   RD_WAIT | waiting for backend read data, then fill entry
module ddr2_responder #(
  parameter int INDEX_W = 10
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ddr2_en,
  input  logic        ddr2_we,
  input  logic [31:0] ddr2_addr,
  input  logic [31:0] ddr2_wd,
  output logic        ddr2_stall,
  output logic [31:0] ddr2_rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [29:0] mem_req_addr,
  output logic [31:0] mem_req_wd,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rd
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int TAG_W   = 30 - INDEX_W;

  typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT} state_t;

  state_t state, state_nxt;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_mem  [ENTRIES];
  logic [31:0]        data_mem [ENTRIES];

  logic [29:0] addr_q;
  logic [31:0] wd_q;
  logic [31:0] rd_q;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [INDEX_W-1:0] fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               accept;
  logic               hit;
  logic               rsp_done;

  assign idx      = ddr2_addr[INDEX_W+1:2];
  assign tag      = ddr2_addr[31:INDEX_W+2];
  assign fill_idx = addr_q[INDEX_W-1:0];
  assign fill_tag = addr_q[29:INDEX_W];
  assign accept   = ddr2_en && (state == IDLE);
  assign hit      = valid_q[idx] && (tag_mem[idx] == tag);
  assign rsp_done = (state == RD_WAIT) && mem_rsp_valid;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state   <= IDLE;
      valid_q <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q <= ddr2_addr[31:2];
        wd_q   <= ddr2_wd;
      end
      if (accept && !ddr2_we && hit) rd_q <= data_mem[idx];
      if (rsp_done) begin
        rd_q              <= mem_rsp_rd;
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag/data arrays carry no reset so they can map onto LUTRAM; valid_q guards them.
  always_ff @(posedge clock) begin
    if (resetn) begin
      if (accept && ddr2_we && hit) data_mem[idx] <= ddr2_wd;
      if (rsp_done) begin
        data_mem[fill_idx] <= mem_rsp_rd;
        tag_mem[fill_idx]  <= fill_tag;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (ddr2_en) begin
          if (ddr2_we)   state_nxt = WR_REQ;
          else if (!hit) state_nxt = RD_REQ;
        end
      end
      WR_REQ:  if (mem_req_ready) state_nxt = IDLE;
      RD_REQ:  if (mem_req_ready) state_nxt = RD_WAIT;
      RD_WAIT: if (mem_rsp_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ddr2_stall    = (state != IDLE);
    mem_req_valid = (state == WR_REQ) || (state == RD_REQ);
    mem_req_we    = (state == WR_REQ);
  end

  assign ddr2_rd      = rd_q;
  assign mem_req_addr = addr_q;
  assign mem_req_wd   = wd_q;

endmodule

// File: tb/tb_ddr2_responder.sv
// Directed bench for ddr2_responder: hand-driven backend, hand-computed expectations.
`timescale 1ns/1ps
module tb_ddr2_responder;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        ddr2_en = 1'b0;
  logic        ddr2_we = 1'b0;
  logic [31:0] ddr2_addr = '0;
  logic [31:0] ddr2_wd = '0;
  logic        ddr2_stall;
  logic [31:0] ddr2_rd;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic        mem_req_we;
  logic [29:0] mem_req_addr;
  logic [31:0] mem_req_wd;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_rd = '0;

  int total = 0;
  int bad = 0;
  int n_rd = 0;
  int n_wr = 0;
  int stall_cnt = 0;
  logic [29:0] last_addr = '0;
  int s0, r0, w0;

  ddr2_responder #(.INDEX_W(10)) dut (
    .clock(clock), .resetn(resetn),
    .ddr2_en(ddr2_en), .ddr2_we(ddr2_we), .ddr2_addr(ddr2_addr), .ddr2_wd(ddr2_wd),
    .ddr2_stall(ddr2_stall), .ddr2_rd(ddr2_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wd(mem_req_wd),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rd(mem_rsp_rd)
  );

  always #5 clock = ~clock;

  // Backend handshake and stall-cycle monitor.
  always @(posedge clock) begin
    if (resetn && mem_req_valid && mem_req_ready) begin
      if (mem_req_we) n_wr <= n_wr + 1;
      else n_rd <= n_rd + 1;
      last_addr <= mem_req_addr;
    end
    if (ddr2_stall) stall_cnt <= stall_cnt + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cpu_req(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    ddr2_en = 1'b1; ddr2_we = we; ddr2_addr = addr; ddr2_wd = wd;
    tick();
    ddr2_en = 1'b0; ddr2_we = 1'b0;
  endtask

  initial begin
    // reset
    tick(); tick();
    chk1("rst_stall", ddr2_stall, 1'b0);
    chk32("rst_rd", ddr2_rd, 32'h0);
    chk1("rst_valid", mem_req_valid, 1'b0);
    chk1("rst_we", mem_req_we, 1'b0);
    chk32("rst_addr", {2'b0, mem_req_addr}, 32'h0);
    chk32("rst_wd", mem_req_wd, 32'h0);
    resetn = 1'b1;
    tick();

    // read miss 0x100, response two cycles after handshake
    s0 = stall_cnt; r0 = n_rd;
    cpu_req(1'b0, 32'h0000_0100, 32'h0);
    chk1("miss1_stall", ddr2_stall, 1'b1);
    chk1("miss1_valid", mem_req_valid, 1'b1);
    chk1("miss1_we", mem_req_we, 1'b0);
    chk32("miss1_addr", {2'b0, mem_req_addr}, 32'h40);
    tick();
    chk1("miss1_wait_valid", mem_req_valid, 1'b0);
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_rd = 32'hDEAD_BEEF;
    tick();
    mem_rsp_valid = 1'b0;
    chk1("miss1_done_stall", ddr2_stall, 1'b0);
    chk32("miss1_rd", ddr2_rd, 32'hDEAD_BEEF);
    chk32("miss1_stall_cycles", 32'(stall_cnt - s0), 32'd3);
    chk32("miss1_backend_reads", 32'(n_rd - r0), 32'd1);
    chk32("miss1_backend_addr", {2'b0, last_addr}, 32'h40);

    // read hit 0x100
    r0 = n_rd;
    cpu_req(1'b0, 32'h0000_0100, 32'h0);
    chk1("hit1_stall", ddr2_stall, 1'b0);
    chk1("hit1_valid", mem_req_valid, 1'b0);
    chk32("hit1_rd", ddr2_rd, 32'hDEAD_BEEF);
    tick();
    chk32("hit1_backend_reads", 32'(n_rd - r0), 32'd0);

    // write hit with ready held low for 4 cycles
    s0 = stall_cnt; w0 = n_wr;
    mem_req_ready = 1'b0;
    cpu_req(1'b1, 32'h0000_0100, 32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      chk1("wr_valid_held", mem_req_valid, 1'b1);
      chk1("wr_we_held", mem_req_we, 1'b1);
      chk32("wr_addr_held", {2'b0, mem_req_addr}, 32'h40);
      chk32("wr_wd_held", mem_req_wd, 32'h1234_5678);
      tick();
    end
    mem_req_ready = 1'b1;
    chk1("wr_stall_last", ddr2_stall, 1'b1);
    tick();
    chk1("wr_done_stall", ddr2_stall, 1'b0);
    chk32("wr_stall_cycles", 32'(stall_cnt - s0), 32'd5);
    chk32("wr_backend_writes", 32'(n_wr - w0), 32'd1);
    chk32("wr_rd_held", ddr2_rd, 32'hDEAD_BEEF);

    // read hit returns written data
    r0 = n_rd;
    cpu_req(1'b0, 32'h0000_0100, 32'h0);
    chk1("hit2_stall", ddr2_stall, 1'b0);
    chk32("hit2_rd", ddr2_rd, 32'h1234_5678);
    tick();
    chk32("hit2_backend_reads", 32'(n_rd - r0), 32'd0);

    // conflicting tag 0x1100, minimum-latency miss
    cpu_req(1'b0, 32'h0000_1100, 32'h0);
    chk1("conf_stall", ddr2_stall, 1'b1);
    chk32("conf_addr", {2'b0, mem_req_addr}, 32'h440);
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_rd = 32'hCAFE_F00D;
    chk1("conf_wait_stall", ddr2_stall, 1'b1);
    tick();
    mem_rsp_valid = 1'b0;
    chk1("conf_done_stall", ddr2_stall, 1'b0);
    chk32("conf_rd", ddr2_rd, 32'hCAFE_F00D);

    // 0x100 was evicted
    cpu_req(1'b0, 32'h0000_0100, 32'h0);
    chk1("evict_stall", ddr2_stall, 1'b1);
    chk32("evict_addr", {2'b0, mem_req_addr}, 32'h40);
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_rd = 32'h1234_5678;
    tick();
    mem_rsp_valid = 1'b0;
    chk32("evict_rd", ddr2_rd, 32'h1234_5678);

    // ddr2_en held high across a miss while address changes
    r0 = n_rd;
    ddr2_en = 1'b1; ddr2_we = 1'b0; ddr2_addr = 32'h0000_2200;
    tick();
    ddr2_addr = 32'h0000_3300;
    chk32("hold_first_addr", {2'b0, mem_req_addr}, 32'h880);
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_rd = 32'h0BAD_F00D;
    tick();
    mem_rsp_valid = 1'b0;
    chk1("hold_gap_stall", ddr2_stall, 1'b0);
    chk1("hold_gap_valid", mem_req_valid, 1'b0);
    chk32("hold_first_rd", ddr2_rd, 32'h0BAD_F00D);
    tick();
    ddr2_en = 1'b0;
    chk1("hold_second_stall", ddr2_stall, 1'b1);
    chk32("hold_second_addr", {2'b0, mem_req_addr}, 32'hCC0);
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_rd = 32'h55AA_55AA;
    tick();
    mem_rsp_valid = 1'b0;
    chk32("hold_second_rd", ddr2_rd, 32'h55AA_55AA);
    tick();
    chk32("hold_backend_reads", 32'(n_rd - r0), 32'd2);

    // reset during RD_WAIT
    cpu_req(1'b0, 32'h0000_0100, 32'h0);
    chk1("pre_rst_hit_stall", ddr2_stall, 1'b0);
    chk32("pre_rst_hit_rd", ddr2_rd, 32'h1234_5678);
    cpu_req(1'b0, 32'h0000_4400, 32'h0);
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk1("midrst_stall", ddr2_stall, 1'b0);
    chk32("midrst_rd", ddr2_rd, 32'h0);
    chk1("midrst_valid", mem_req_valid, 1'b0);
    mem_rsp_valid = 1'b1; mem_rsp_rd = 32'h7777_7777;
    tick();
    mem_rsp_valid = 1'b0;
    chk1("late_rsp_stall", ddr2_stall, 1'b0);
    chk32("late_rsp_rd", ddr2_rd, 32'h0);
    cpu_req(1'b0, 32'h0000_0100, 32'h0);
    chk1("postrst_miss_stall", ddr2_stall, 1'b1);
    chk1("postrst_miss_valid", mem_req_valid, 1'b1);
    chk32("postrst_miss_addr", {2'b0, mem_req_addr}, 32'h40);
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_rd = 32'h1234_5678;
    tick();
    mem_rsp_valid = 1'b0;
    chk32("postrst_miss_rd", ddr2_rd, 32'h1234_5678);
    chk1("postrst_done_stall", ddr2_stall, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
